// File: rtl/btb_pkg.sv
// btb_pkg: shared widths, counter type and counter constants for the BTB
package btb_pkg;
  localparam int PC_W = 32;
  typedef logic [1:0] ctr2_t;
  localparam ctr2_t CTR_INIT  = 2'b10;
  localparam ctr2_t CTR_RESET = 2'b00;
endpackage

// File: rtl/sat_ctr2.sv
// sat_ctr2: 2-bit saturating up/down counter step
module sat_ctr2 import btb_pkg::*; (
  input  ctr2_t c_i,
  input  logic  up_i,
  output ctr2_t c_o
);
  assign c_o = up_i ? (c_i == 2'b11 ? c_i : c_i + 2'd1) : (c_i == 2'b00 ? c_i : c_i - 2'd1);
endmodule

// File: rtl/btb_assoc.sv
// btb_assoc: 2-way set-associative branch target buffer, 1-cycle lookup; BTB_COUNTER_EN adds 2-bit direction counters
module btb_assoc import btb_pkg::*; #(
  parameter int PC  = PC_W,
  parameter int IDX = 4
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          lookup_valid_in,
  input  logic [PC-1:0] lookup_pc_in,
  output logic          pred_valid_out,
  output logic          pred_hit_out,
  output logic          pred_taken_out,
  output logic [PC-1:0] pred_target_out,
  input  logic          update_in,
  input  logic [PC-1:0] update_pc_in,
  input  logic [PC-1:0] update_target_in,
  input  logic          update_taken_in
);
  localparam int SETS = 1 << IDX;
  localparam int TAGW = PC - IDX - 2;
  logic [1:0]      val_q [SETS];
  logic [SETS-1:0] lru_q;
  logic [TAGW-1:0] tag_q [SETS][2];
  logic [PC-1:0]   tgt_q [SETS][2];
  logic            pv_q, hit_q, taken_q;
  logic [PC-1:0]   ptgt_q;
  logic [IDX-1:0]  lidx, uidx;
  logic [TAGW-1:0] ltag, utag;
  logic            lm0, lm1, lway, hit_d, taken_d;
  logic [PC-1:0]   tgt_d;
  logic            um0, um1, uhit, uway, victim, wway;
  logic [1:0]      unused_pc;
`ifdef BTB_COUNTER_EN
  ctr2_t ctr_q [SETS][2];
  ctr2_t ctr_d [2];
  for (genvar w = 0; w < 2; w++) begin : g_ctr
    sat_ctr2 u_ctr (.c_i(ctr_q[uidx][w]), .up_i(update_taken_in), .c_o(ctr_d[w]));
  end
`endif
  assign unused_pc = lookup_pc_in[1:0] ^ update_pc_in[1:0];
  // lookup match against the pre-update contents; way 0 wins a double match
  always_comb begin
    lidx = lookup_pc_in[IDX+1:2];
    ltag = lookup_pc_in[PC-1:IDX+2];
    lm0 = val_q[lidx][0] && tag_q[lidx][0] == ltag;
    lm1 = val_q[lidx][1] && tag_q[lidx][1] == ltag;
    lway = !lm0;
    hit_d = lookup_valid_in && (lm0 || lm1);
    tgt_d = hit_d ? tgt_q[lidx][lway] : '0;
`ifdef BTB_COUNTER_EN
    taken_d = hit_d && ctr_q[lidx][lway][1];
`else
    taken_d = hit_d;
`endif
  end
  // update match and victim choice: first invalid way, else the LRU way
  always_comb begin
    uidx = update_pc_in[IDX+1:2];
    utag = update_pc_in[PC-1:IDX+2];
    um0 = val_q[uidx][0] && tag_q[uidx][0] == utag;
    um1 = val_q[uidx][1] && tag_q[uidx][1] == utag;
    uhit = um0 || um1;
    uway = !um0;
    victim = !val_q[uidx][0] ? 1'b0 : !val_q[uidx][1] ? 1'b1 : lru_q[uidx];
    wway = uhit ? uway : victim;
  end
  // valid/LRU/counter state and registered prediction; update LRU write follows lookup so it wins
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < SETS; i++) begin
        val_q[i] <= '0;
`ifdef BTB_COUNTER_EN
        ctr_q[i][0] <= CTR_RESET;
        ctr_q[i][1] <= CTR_RESET;
`endif
      end
      lru_q <= '0;
      pv_q <= 1'b0;
      hit_q <= 1'b0;
      taken_q <= 1'b0;
      ptgt_q <= '0;
    end else begin
      pv_q <= lookup_valid_in;
      hit_q <= hit_d;
      taken_q <= taken_d;
      ptgt_q <= tgt_d;
      if (hit_d) lru_q[lidx] <= !lway;
      if (update_in) begin
        if (uhit) begin
          if (update_taken_in) lru_q[uidx] <= !uway;
`ifdef BTB_COUNTER_EN
          ctr_q[uidx][uway] <= ctr_d[uway];
`else
          if (!update_taken_in) val_q[uidx][uway] <= 1'b0;
`endif
        end else if (update_taken_in) begin
          val_q[uidx][victim] <= 1'b1;
          lru_q[uidx] <= !victim;
`ifdef BTB_COUNTER_EN
          ctr_q[uidx][victim] <= CTR_INIT;
`endif
        end
      end
    end
  end
  // tag/target payload, meaningless while invalid so never reset
  always_ff @(posedge clk_in) begin
    if (update_in && update_taken_in) begin
      tag_q[uidx][wway] <= utag;
      tgt_q[uidx][wway] <= update_target_in;
    end
  end
  assign pred_valid_out = pv_q;
  assign pred_hit_out = hit_q;
  assign pred_taken_out = taken_q;
  assign pred_target_out = ptgt_q;
endmodule

// File: tb/tb_btb_assoc.sv
// tb_btb_assoc: randomized and directed check of btb_assoc against a recency-stamp reference model
module tb_btb_assoc;
  localparam int PC = 32;
  localparam int IDX = 4;
  localparam int SETS = 1 << IDX;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lv = 1'b0, uv = 1'b0, ut = 1'b0;
  logic [PC-1:0] lpc = '0, upc = '0, utg = '0;
  logic pv, ph, pt;
  logic [PC-1:0] ptg;
  int errs = 0;
  int checks = 0;
  logic m_v [SETS][2];
  logic [PC-1:0] m_key [SETS][2];
  logic [PC-1:0] m_tg [SETS][2];
  int m_ctr [SETS][2];
  int m_st [SETS][2];
  int stamp = 0;
  logic e_h, e_t;
  logic [PC-1:0] e_tg;
  always #5 clk = ~clk;
  btb_assoc #(.PC(PC), .IDX(IDX)) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .lookup_valid_in(lv), .lookup_pc_in(lpc),
    .pred_valid_out(pv), .pred_hit_out(ph), .pred_taken_out(pt), .pred_target_out(ptg),
    .update_in(uv), .update_pc_in(upc), .update_target_in(utg), .update_taken_in(ut)
  );
  task automatic chk(input string tag, input logic [PC-1:0] got, input logic [PC-1:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < 2; w++) begin
        m_v[s][w] = 1'b0;
        m_ctr[s][w] = 0;
        m_st[s][w] = 0;
      end
  endtask
  function automatic int mfind(input logic [PC-1:0] pc);
    int s = int'(pc[IDX+1:2]);
    for (int w = 0; w < 2; w++)
      if (m_v[s][w] && m_key[s][w] == (pc >> (IDX + 2))) return w;
    return -1;
  endfunction
  function automatic logic [PC-1:0] rpc();
    return PC'(($urandom_range(0, 5) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
  endfunction
  task automatic cycle(input logic l_v, input logic [PC-1:0] l_pc, input logic u_v,
                       input logic [PC-1:0] u_pc, input logic [PC-1:0] u_tg, input logic u_t);
    int ls, lw, us, uw, vic;
    lv = l_v; lpc = l_pc; uv = u_v; upc = u_pc; utg = u_tg; ut = u_t;
    ls = int'(l_pc[IDX+1:2]);
    lw = l_v ? mfind(l_pc) : -1;
    e_h = lw >= 0;
    e_tg = e_h ? m_tg[ls][lw] : '0;
`ifdef BTB_COUNTER_EN
    e_t = e_h && m_ctr[ls][lw] >= 2;
`else
    e_t = e_h;
`endif
    us = int'(u_pc[IDX+1:2]);
    uw = mfind(u_pc);
    vic = !m_v[us][0] ? 0 : !m_v[us][1] ? 1 : (m_st[us][0] < m_st[us][1] ? 0 : 1);
    if (e_h) m_st[ls][lw] = ++stamp;
    if (u_v) begin
      if (uw >= 0) begin
`ifdef BTB_COUNTER_EN
        m_ctr[us][uw] = u_t ? (m_ctr[us][uw] == 3 ? 3 : m_ctr[us][uw] + 1)
                            : (m_ctr[us][uw] == 0 ? 0 : m_ctr[us][uw] - 1);
`else
        if (!u_t) m_v[us][uw] = 1'b0;
`endif
        if (u_t) begin
          m_tg[us][uw] = u_tg;
          m_st[us][uw] = ++stamp;
        end
      end else if (u_t) begin
        m_v[us][vic] = 1'b1;
        m_key[us][vic] = u_pc >> (IDX + 2);
        m_tg[us][vic] = u_tg;
        m_ctr[us][vic] = 2;
        m_st[us][vic] = ++stamp;
      end
    end
    @(posedge clk);
    #1;
    chk("valid", PC'(pv), PC'(l_v));
    chk("hit", PC'(ph), PC'(e_h));
    chk("taken", PC'(pt), PC'(e_t));
    chk("target", ptg, e_tg);
  endtask
  task automatic look(input logic [PC-1:0] pc);
    cycle(1'b1, pc, 1'b0, '0, '0, 1'b0);
  endtask
  task automatic upd(input logic [PC-1:0] pc, input logic [PC-1:0] tg, input logic t);
    cycle(1'b0, '0, 1'b1, pc, tg, t);
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", PC'(pv), '0);
    chk("rst_hit", PC'(ph), '0);
    chk("rst_target", ptg, '0);
    rst_n = 1'b1;
    look(32'h100);
    chk("first_miss", PC'(ph), '0);
    upd(32'h100, 32'h400, 1'b1);
    look(32'h100);
    chk("hit_target", ptg, 32'h400);
    chk("hit_taken", PC'(pt), 32'd1);
    look(32'h102);
    chk("lowbits_hit", PC'(ph), 32'd1);
    upd(32'h500, 32'h1500, 1'b1);
    upd(32'h900, 32'h1900, 1'b1);
    look(32'h500);
    upd(32'hD00, 32'h1D00, 1'b1);
    look(32'h100);
    look(32'h500);
    chk("lru_keep_500", PC'(ph), 32'd1);
    look(32'h900);
    look(32'hD00);
    upd(32'h100, 32'h400, 1'b1);
    look(32'h100);
`ifdef BTB_COUNTER_EN
    upd(32'h100, 32'h400, 1'b0);
    upd(32'h100, 32'h400, 1'b0);
    look(32'h100);
    chk("ctr_nt_hit", PC'(ph), 32'd1);
    chk("ctr_nt_taken", PC'(pt), '0);
    upd(32'h100, 32'h400, 1'b1);
    upd(32'h100, 32'h400, 1'b1);
    look(32'h100);
    chk("ctr_t_taken", PC'(pt), 32'd1);
`else
    upd(32'h100, 32'h400, 1'b0);
    look(32'h100);
    chk("nt_invalidate", PC'(ph), '0);
`endif
    cycle(1'b1, 32'h200, 1'b1, 32'h200, 32'h777, 1'b1);
    chk("rbw_miss", PC'(ph), '0);
    look(32'h200);
    chk("rbw_new_target", ptg, 32'h777);
    for (int i = 0; i < 3000; i++)
      cycle(1'($urandom_range(0, 1)), rpc(), 1'($urandom_range(0, 1)), rpc(),
            PC'($urandom), 1'($urandom_range(0, 3) != 0));
    upd(32'h200, 32'h888, 1'b1);
    lv = 1'b1; lpc = 32'h200; uv = 1'b0;
    @(posedge clk);
    #2;
    chk("pre_rst_hit", PC'(ph), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_valid", PC'(pv), '0);
    chk("async_hit", PC'(ph), '0);
    chk("async_target", ptg, '0);
    @(posedge clk);
    #1;
    chk("held_valid", PC'(pv), '0);
    model_reset();
    rst_n = 1'b1;
    look(32'h200);
    chk("post_rst_miss", PC'(ph), '0);
    look(32'h100);
    look(32'h500);
    look(32'h900);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/btb_assoc.md
BTB_ASSOC -- requirements
Module: btb_assoc

Interface
REQ-001 SHALL have parameter PC, default 32: program-counter and target width in bits.
REQ-002 SHALL have parameter IDX, default 4: set-index width; 2**IDX sets, 2 ways per set.
REQ-003 SHALL derive tag width TAGW = PC-IDX-2, covering pc[PC-1:IDX+2]; pc[1:0] ignored.
REQ-004 SHALL use one clock, clk_in; reset is asynchronous and active-low, rst_n_in.
REQ-005 Ports SHALL be, as name  direction  width  meaning:
- clk_in  input  1  clock; all state changes on posedge.
- rst_n_in  input  1  async active-low reset.
- lookup_valid_in  input  1  lookup request this cycle.
- lookup_pc_in  input  PC  fetch PC to look up.
- pred_valid_out  output  1  registered: result of the previous cycle's lookup.
- pred_hit_out  output  1  tag matched a valid way.
- pred_taken_out  output  1  predicted taken.
- pred_target_out  output  PC  predicted target; 0 on miss.
- update_in  input  1  resolved-branch update this cycle.
- update_pc_in  input  PC  branch PC.
- update_target_in  input  PC  resolved target.
- update_taken_in  input  1  branch resolved taken.

Function
REQ-006 Set index SHALL be pc[IDX+1:2]; tag SHALL be pc[PC-1:IDX+2].
REQ-007 Each way SHALL hold valid, tag and target; each set SHALL hold one LRU bit naming the way to evict next.
REQ-008 Lookup latency SHALL be exactly 1 cycle: pred_valid_out = lookup_valid_in registered.
REQ-009 When pred_valid_out=0, pred_hit_out, pred_taken_out and pred_target_out SHALL be 0.
REQ-010 Hit means one way is valid with a matching tag. Both ways matching is illegal (the allocation rules prevent it); in that case way 0 SHALL win.
REQ-011 On a lookup hit, the set's LRU bit SHALL be set to point at the other way.
REQ-012 Update hit, taken: the way's target SHALL be overwritten with update_target_in, and LRU SHALL be set to the other way.
REQ-013 Update miss, taken: allocation SHALL pick the first invalid way (way 0 before way 1), else the LRU way. The victim is written valid with the new tag and target, and LRU is set to the other way.
REQ-014 Update miss, not taken: there SHALL be no state change.
REQ-015 Lookup and update in the same cycle to the same set SHALL be read-before-write: the lookup sees the old contents.
REQ-016 If a lookup hit and an update touch the same set's LRU in the same cycle, the update's LRU value SHALL win.
REQ-017 There SHALL be no backpressure: a lookup and an update are accepted every cycle.

Reset
REQ-018 Asserting rst_n_in low SHALL immediately clear all valid bits, all LRU bits and all outputs, including in the middle of a lookup; a result pending at reset SHALL be discarded.
REQ-019 Tags and targets SHALL need no reset value; they are unobservable while valid=0.

Configuration
REQ-020 Macro BTB_COUNTER_EN defined:
- Each way SHALL carry a 2-bit saturating counter, initialised to 2'b10 on allocation and reset to 2'b00.
- pred_taken_out SHALL equal hit AND counter[1].
- Update hit SHALL increment the counter (saturating at 3) if taken, else decrement it (saturating at 0); the entry stays valid.
REQ-021 Macro BTB_COUNTER_EN undefined:
- There SHALL be no counters, and pred_taken_out SHALL equal pred_hit_out.
- Update hit, not taken, SHALL clear that way's valid bit; LRU is unchanged.

Structure
REQ-022 Package btb_pkg SHALL hold the default PC width, the ctr2_t 2-bit counter typedef and the constants CTR_INIT=2'b10 and CTR_RESET=2'b00.
REQ-023 Sub-module sat_ctr2 (saturating 2-bit update function/module) SHALL be instantiated per way only under BTB_COUNTER_EN.

Verification
REQ-024 Reset, then lookup 0x0000_0100 -> next cycle pred_valid_out=1, hit=0, taken=0, target=0.
REQ-025 Update pc 0x100, target 0x400, taken; then lookup 0x100 -> hit=1, target=0x400, taken=1; lookup 0x102 also hits (pc[1:0] ignored).
REQ-026 Three taken updates to 0x100, 0x500 and 0x900 (same set, IDX=4), then lookup 0x500, then update 0xD00 -> 0x100 evicted, 0x500/0x900/0xD00 behaviour per LRU, 0x500 still hits.
REQ-027 With BTB_COUNTER_EN: allocate 0x100, then two not-taken updates -> taken=0 while hit=1; then two taken updates -> taken=1. Without the macro: one not-taken update -> hit=0.
REQ-028 Same-cycle lookup and taken update of 0x200 to a new target -> the lookup returns the old result (miss); the following lookup hits with the new target.
REQ-029 Assert rst_n_in asynchronously mid-lookup -> outputs 0 immediately; after release, every previously allocated PC misses.
